// File: rtl/mux_4to1_serial_pkg.sv
// mux_4to1_serial_pkg: shared widths, lane count and state encoding for the serializer
package mux_4to1_serial_pkg;
   localparam int LANES  = 4;
   localparam int BYTE_W = 8;
   localparam int SEL_W  = 2;
   typedef logic [SEL_W-1:0] sel_t;
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
   localparam sel_t LAST_SEL = sel_t'(LANES - 1);
endpackage

// File: rtl/mux4to1_sel.sv
// mux4to1_sel: picks one held lane by slot index; an invalid lane reads as a zero byte
module mux4to1_sel
   import mux_4to1_serial_pkg::*;
(
   input  logic [LANES-1:0][BYTE_W-1:0] hold_data,
   input  logic [LANES-1:0]             hold_valid,
   input  sel_t                         sel,
   output logic [BYTE_W-1:0]            lane_data,
   output logic                         lane_valid
);
   // lane selection, masking data of lanes that were not valid
   always_comb begin
      lane_valid = hold_valid[sel];
      lane_data  = lane_valid ? hold_data[sel] : '0;
   end
endmodule

// File: rtl/mux_4to1_serial.sv
// mux_4to1_serial: captures a 4-lane byte group and streams it out one lane per cycle
module mux_4to1_serial
   import mux_4to1_serial_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in0,
   input  logic [BYTE_W-1:0] data_in1,
   input  logic [BYTE_W-1:0] data_in2,
   input  logic [BYTE_W-1:0] data_in3,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   output logic              in_ready,
   output logic [BYTE_W-1:0] data_out,
   output logic              valid_out
);
   state_t                      state;
   sel_t                        sel;
   logic [LANES-1:0][BYTE_W-1:0] hold_data;
   logic [LANES-1:0]             hold_valid;
   logic [BYTE_W-1:0]            lane_data;
   logic                         lane_valid;
   logic                         accept;

   assign in_ready = (state == IDLE) || (sel == LAST_SEL);
   assign accept   = in_ready && (valid_in0 || valid_in1 || valid_in2 || valid_in3);

   mux4to1_sel u_sel (
      .hold_data (hold_data),
      .hold_valid(hold_valid),
      .sel       (sel),
      .lane_data (lane_data),
      .lane_valid(lane_valid)
   );

   // group capture, slot sequencing and registered serial output; a new group at the last slot chains without a gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sel        <= '0;
         hold_data  <= '0;
         hold_valid <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
      end else begin
         data_out  <= (state == SEND) ? lane_data : '0;
         valid_out <= (state == SEND) && lane_valid;
         if (state == SEND) begin
            sel <= sel + sel_t'(1);
            if (sel == LAST_SEL) state <= IDLE;
         end
         if (accept) begin
            hold_data  <= {data_in3, data_in2, data_in1, data_in0};
            hold_valid <= {valid_in3, valid_in2, valid_in1, valid_in0};
            state      <= SEND;
            sel        <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mux_4to1_serial.sv
// tb_mux_4to1_serial: directed and randomized checks of the serializer against a queue model
module tb_mux_4to1_serial;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
   logic       in_ready;
   logic [7:0] data_out;
   logic       valid_out;

   int   n_pass = 0;
   int   n_total = 0;
   bit   armed = 1'b0;

   logic [8:0] q[$];
   logic [7:0] m_data = '0;
   logic       m_valid = 1'b0;

   mux_4to1_serial dut (
      .clk      (clk),
      .reset    (reset),
      .data_in0 (data_in0),
      .data_in1 (data_in1),
      .data_in2 (data_in2),
      .data_in3 (data_in3),
      .valid_in0(valid_in0),
      .valid_in1(valid_in1),
      .valid_in2(valid_in2),
      .valid_in3(valid_in3),
      .in_ready (in_ready),
      .data_out (data_out),
      .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // reference: a queue of pending lanes; one lane leaves per edge, a group may enter when at most one is left
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_data  = '0;
         m_valid = 1'b0;
      end else begin
         bit rdy;
         logic [7:0] d[4];
         logic [3:0] v;
         rdy = (q.size() <= 1);
         if (q.size() > 0) begin
            logic [8:0] e;
            e = q.pop_front();
            {m_valid, m_data} = e;
         end else begin
            m_data  = '0;
            m_valid = 1'b0;
         end
         d = '{data_in0, data_in1, data_in2, data_in3};
         v = {valid_in3, valid_in2, valid_in1, valid_in0};
         if (rdy && (v != 4'b0))
            for (int i = 0; i < 4; i++) q.push_back({v[i], v[i] ? d[i] : 8'h00});
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (armed) begin
         chk("model_data_out", {24'b0, data_out}, {24'b0, m_data});
         chk("model_valid_out", {31'b0, valid_out}, {31'b0, m_valid});
         chk("model_in_ready", {31'b0, in_ready}, {31'b0, q.size() <= 1});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d0, d1, d2, d3, input logic [3:0] v);
      data_in0 = d0; data_in1 = d1; data_in2 = d2; data_in3 = d3;
      {valid_in3, valid_in2, valid_in1, valid_in0} = v;
   endtask

   task automatic out_is(input string name, input logic [7:0] d, input logic v);
      chk({name, "_data"}, {24'b0, data_out}, {24'b0, d});
      chk({name, "_valid"}, {31'b0, valid_out}, {31'b0, v});
   endtask

   initial begin
      logic [7:0] exp_b[8];
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      tick();
      armed = 1'b1;
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'hF);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 4'h0);
      out_is("reset", 8'h00, 1'b0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

      drive(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'hF);
      tick();
      drive(0, 0, 0, 0, 4'h0);
      exp_b = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 0, 0, 0, 0};
      for (int k = 0; k < 4; k++) begin
         tick();
         out_is("single", exp_b[k], 1'b1);
      end
      tick();
      out_is("single_end", 8'h00, 1'b0);
      chk("single_idle_ready", {31'b0, in_ready}, 32'd1);

      drive(8'h10, 8'h11, 8'h12, 8'h13, 4'hF);
      chk("b2b_ready0", {31'b0, in_ready}, 32'd1);
      tick();
      drive(8'h20, 8'h21, 8'h22, 8'h23, 4'hF);
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
      chk("b2b_ready1", {31'b0, in_ready}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 3) drive(0, 0, 0, 0, 4'h0);
         out_is("b2b", exp_b[k], 1'b1);
         if (k < 3) chk("b2b_ready", {31'b0, in_ready}, (k == 2) ? 32'd1 : 32'd0);
      end
      tick();
      out_is("b2b_end", 8'h00, 1'b0);

      drive(8'h11, 8'h22, 8'h33, 8'h44, 4'b0101);
      tick();
      drive(0, 0, 0, 0, 4'h0);
      tick(); out_is("partial0", 8'h11, 1'b1);
      tick(); out_is("partial1", 8'h00, 1'b0);
      tick(); out_is("partial2", 8'h33, 1'b1);
      tick(); out_is("partial3", 8'h00, 1'b0);
      tick();

      drive(8'h51, 8'h52, 8'h53, 8'h54, 4'hF);
      tick();
      drive(0, 0, 0, 0, 4'h0);
      tick(); out_is("blocked0", 8'h51, 1'b1);
      drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
      tick(); out_is("blocked1", 8'h52, 1'b1);
      tick(); out_is("blocked2", 8'h53, 1'b1);
      drive(0, 0, 0, 0, 4'h0);
      tick(); out_is("blocked3", 8'h54, 1'b1);
      tick(); out_is("blocked_end", 8'h00, 1'b0);

      drive(8'h61, 8'h62, 8'h63, 8'h64, 4'hF);
      tick();
      drive(0, 0, 0, 0, 4'h0);
      tick(); out_is("midrst0", 8'h61, 1'b1);
      tick(); out_is("midrst1", 8'h62, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_is("midrst_rst", 8'h00, 1'b0);
      chk("midrst_ready", {31'b0, in_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         out_is("midrst_after", 8'h00, 1'b0);
      end

      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 39) == 0);
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 1) ? 4'($urandom) : 4'h0);
         tick();
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 4'h0);
      for (int k = 0; k < 6; k++) tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
